// File: rtl/sr_deser_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from sin on en strobes and holds them on dout with valid/ready.
// Optional even-parity bit after each word when SR_DESER_PARITY_EN is defined.
module sr_deser_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       en,
  input  logic                       clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overrun,
  output logic                       parity_err
);

  localparam int CW = $clog2(WIDTH+1);

`ifdef SR_DESER_PARITY_EN
  typedef enum logic {COLLECT = 1'b0, PARITY = 1'b1} state_t;
`else
  typedef enum logic {COLLECT = 1'b0} state_t;
`endif

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sh, sh_nxt, shifted, word;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              deliver;
`ifdef SR_DESER_PARITY_EN
  logic              perr_new;
`endif

  assign shifted = MSB_FIRST ? {sh[WIDTH-2:0], sin} : {sin, sh[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    deliver   = 1'b0;
    word      = shifted;
`ifdef SR_DESER_PARITY_EN
    perr_new  = 1'b0;
`endif
    if (clr) begin
      state_nxt = COLLECT;
      sh_nxt    = '0;
      cnt_nxt   = '0;
    end else if (en) begin
`ifdef SR_DESER_PARITY_EN
      if (state == PARITY) begin
        // word waits in sh during PARITY; this strobe carries the parity bit
        deliver   = 1'b1;
        word      = sh;
        perr_new  = (^sh) ^ sin;
        state_nxt = COLLECT;
      end else
`endif
      begin
        sh_nxt = shifted;
        if (cnt == CW'(WIDTH-1)) begin
          cnt_nxt = '0;
`ifdef SR_DESER_PARITY_EN
          state_nxt = PARITY;
`else
          deliver = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // a full holding register only takes a new word if it is being drained this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (deliver && (!dout_valid || dout_ready)) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (clr)
        overrun <= 1'b0;
      else if (deliver && dout_valid && !dout_ready)
        overrun <= 1'b1;
    end
  end

`ifdef SR_DESER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      parity_err <= 1'b0;
    else if (deliver && (!dout_valid || dout_ready))
      parity_err <= perr_new;
  end

  assign bit_cnt = (state == PARITY) ? CW'(WIDTH) : cnt;
`else
  assign parity_err = 1'b0;
  assign bit_cnt    = cnt;
`endif

endmodule

// File: tb/tb_sr_deser_rx.sv
// Drives an MSB-first and an LSB-first receiver with shared inputs and checks both against a bit-queue reference model.
module tb_sr_deser_rx;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);
`ifdef SR_DESER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sin = 1'b0, en = 1'b0, clr = 1'b0, dout_ready = 1'b0;
  logic [W-1:0]  dout_m, dout_l;
  logic          vld_m, vld_l, ovr_m, ovr_l, perr_m, perr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit           bits[$];
  logic [W-1:0] m_msb, m_lsb;
  logic         m_valid, m_ovr, m_perr;

  always #5 clk = ~clk;

  sr_deser_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .sin(sin), .en(en), .clr(clr),
    .dout(dout_m), .dout_valid(vld_m), .dout_ready(dout_ready),
    .bit_cnt(cnt_m), .overrun(ovr_m), .parity_err(perr_m));

  sr_deser_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .sin(sin), .en(en), .clr(clr),
    .dout(dout_l), .dout_valid(vld_l), .dout_ready(dout_ready),
    .bit_cnt(cnt_l), .overrun(ovr_l), .parity_err(perr_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    m_msb = '0; m_lsb = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  // one clock edge of the model, using the input values present at that edge
  task automatic model_edge();
    logic         deliver;
    logic [W-1:0] wm, wl;
    logic         p;
    deliver = 1'b0; wm = '0; wl = '0; p = 1'b0;
    if (clr) begin
      bits.delete();
      m_ovr = 1'b0;
    end else if (en) begin
      bits.push_back(sin);
      if (bits.size() == FRAME) begin
        deliver = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bits[i];
          wl[i]     = bits[i];
        end
        for (int i = 0; i < FRAME; i++) p ^= bits[i];
`ifndef SR_DESER_PARITY_EN
        p = 1'b0;
`endif
        bits.delete();
      end
    end
    if (deliver) begin
      if (!m_valid || dout_ready) begin
        m_msb = wm; m_lsb = wl; m_valid = 1'b1; m_perr = p;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && dout_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("dout_msb",  dout_m, m_msb);
    chk("dout_lsb",  dout_l, m_lsb);
    chk("valid_msb", vld_m,  m_valid);
    chk("valid_lsb", vld_l,  m_valid);
    chk("cnt_msb",   cnt_m,  bits.size());
    chk("cnt_lsb",   cnt_l,  bits.size());
    chk("ovr_msb",   ovr_m,  m_ovr);
    chk("ovr_lsb",   ovr_l,  m_ovr);
    chk("perr_msb",  perr_m, m_perr);
    chk("perr_lsb",  perr_l, m_perr);
  endtask

  task automatic step(input logic s, input logic e, input logic c, input logic r);
    sin = s; en = e; clr = c; dout_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic r);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b1, 1'b0, r);
  endtask

  // even parity bit in the parity build, nothing otherwise
  task automatic parity_bit(input logic [7:0] v, input logic r);
`ifdef SR_DESER_PARITY_EN
    step(^v, 1'b1, 1'b0, r);
`else
    if (r && v == 8'h00) sin = 1'b0;
`endif
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_dout",  dout_m, 0);
    chk("rst_valid", vld_m, 0);
    chk("rst_cnt",   cnt_m, 0);
    chk("rst_ovr",   ovr_m, 0);
    chk("rst_perr",  perr_m, 0);
    #10 reset = 1'b1;

    // 0xA5 both bit orders, then consume
    send_byte(8'hA5, 1'b0); parity_bit(8'hA5, 1'b0);
    chk("t1_dout_msb", dout_m, 8'hA5);
    chk("t1_dout_lsb", dout_l, 8'hA5);
    chk("t1_valid", vld_m, 1);
    chk("t1_cnt", cnt_m, 0);
    drain();
    chk("t1_consumed", vld_m, 0);

    // 1,1,0,0,0,0,0,0
    send_byte(8'hC0, 1'b0); parity_bit(8'hC0, 1'b0);
    chk("t2_dout_msb", dout_m, 8'hC0);
    chk("t2_dout_lsb", dout_l, 8'h03);
    drain();

    // overrun with consumer stalled, then clr
    send_byte(8'h3C, 1'b0); parity_bit(8'h3C, 1'b0);
    send_byte(8'h81, 1'b0); parity_bit(8'h81, 1'b0);
    chk("t3_dout", dout_m, 8'h3C);
    chk("t3_ovr", ovr_m, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_clr_ovr", ovr_m, 0);
    chk("t3_clr_dout", dout_m, 8'h3C);
    chk("t3_clr_valid", vld_m, 1);
    drain();

    // back-to-back words with ready high
    send_byte(8'h11, 1'b1); parity_bit(8'h11, 1'b1);
    chk("t4_dout1", dout_m, 8'h11);
    send_byte(8'h22, 1'b1); parity_bit(8'h22, 1'b1);
    chk("t4_dout2", dout_m, 8'h22);
    chk("t4_ovr", ovr_m, 0);
    drain();

    // word split by an en gap
    for (int i = 7; i >= 4; i--) step(8'h96 >> i, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_gap_cnt", cnt_m, 4);
    for (int i = 3; i >= 0; i--) step(8'h96 >> i, 1'b1, 1'b0, 1'b0);
    parity_bit(8'h96, 1'b0);
    chk("t5_gap_dout", dout_m, 8'h96);
    drain();

    // abort by clr
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_clr_cnt", cnt_m, 0);
    send_byte(8'h5A, 1'b0); parity_bit(8'h5A, 1'b0);
    chk("t5_clr_dout", dout_m, 8'h5A);

    // asynchronous reset mid-word with a word held
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    chk("t5_arst_dout", dout_m, 0);
    chk("t5_arst_valid", vld_m, 0);
    chk("t5_arst_cnt", cnt_m, 0);
    chk("t5_arst_ovr", ovr_m, 0);
    #2 reset = 1'b1;

`ifdef SR_DESER_PARITY_EN
    send_byte(8'hA5, 1'b0);
    chk("t6_cnt_parity", cnt_m, W);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_perr_good", perr_m, 0);
    chk("t6_dout", dout_m, 8'hA5);
    drain();
    send_byte(8'hA5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_perr_bad", perr_m, 1);
    drain();
`endif

    // randomized traffic
    for (int n = 0; n < 1500; n++)
      step($urandom_range(0, 1), ($urandom_range(0, 9) < 7), ($urandom_range(0, 59) == 0),
           $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
